// File: rtl/tsal_pkg.sv
// Shared definitions for the TSAL sample sequencer: data width, forced
// fault value, FSM state encoding and a counter-width helper.
package tsal_pkg;

    localparam int DATA_W = 8;

    // Full-scale value presented once the ADC is considered dead, so the
    // comparator reports the tractive system as active.
    localparam logic [DATA_W-1:0] FAULT_DATA = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_PRESENT = 2'd3
    } seq_state_t;

    // Width of a counter that must hold values 0..max_val (at least 1 bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tsal_tick_gen.sv
// Sample-period divider: counts 0..DIV-1 while enabled and flags the last
// count as a tick. Disabling holds the count at zero, so the first tick
// after enable rises arrives a full period later.
module tsal_tick_gen
    import tsal_pkg::*;
#(
    parameter int DIV = 8000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int             CW   = cnt_w(DIV - 1);
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] count_reg;

    assign tick = enable && (count_reg == LAST);

    // Free-running period counter, held at zero while disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (!enable || (count_reg == LAST)) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/tsal_sample_sequencer.sv
// TSAL sample sequencer: triggers the ADC once per sample period, waits a
// bounded time for the result, and presents it to the comparator with a
// data_ready strobe. Consecutive missed conversions latch a sticky fault
// after which every presented sample is forced to full scale.
module tsal_sample_sequencer
    import tsal_pkg::*;
#(
    parameter int SAMPLE_DIV  = 8000,
    parameter int TIMEOUT_CYC = 64,
    parameter int STROBE_CYC  = 2,
    parameter int FAULT_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              adc_start,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_data,
    output logic [DATA_W-1:0] data,
    output logic              data_ready,
    output logic              fault,
    output logic              overrun
);

    localparam int TW = cnt_w(TIMEOUT_CYC);
    localparam int SW = cnt_w(STROBE_CYC);
    localparam int MW = cnt_w(FAULT_LIMIT);

    // Timeout counter is cleared in START, so the last allowed WAIT cycle
    // (TIMEOUT_CYC clocks after adc_start) sees TIMEOUT_CYC-1.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [SW-1:0] STR_LAST = SW'(STROBE_CYC - 1);
    localparam logic [MW-1:0] MISS_MAX = MW'(FAULT_LIMIT);

    seq_state_t        state_reg, state_next;
    logic [TW-1:0]     tmo_cnt_reg, tmo_cnt_next;
    logic [SW-1:0]     str_cnt_reg, str_cnt_next;
    logic [MW-1:0]     miss_cnt_reg, miss_cnt_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              fault_reg, fault_next;

    logic              tick;
    logic [MW-1:0]     miss_inc;
    logic              miss_fault;

    tsal_tick_gen #(
        .DIV (SAMPLE_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick)
    );

    // Saturating miss count and whether this miss leaves the block faulted.
    assign miss_inc   = (miss_cnt_reg == MISS_MAX) ? miss_cnt_reg : miss_cnt_reg + 1'b1;
    assign miss_fault = fault_reg || (miss_inc == MISS_MAX);

    // A tick that finds the sequencer busy is dropped and flagged.
    assign overrun = tick && (state_reg != ST_IDLE);
    assign data    = data_reg;
    assign fault   = fault_reg;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            tmo_cnt_reg  <= '0;
            str_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
            data_reg     <= '0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            str_cnt_reg  <= str_cnt_next;
            miss_cnt_reg <= miss_cnt_next;
            data_reg     <= data_next;
            fault_reg    <= fault_next;
        end
    end

    // Next-state and output decode for the start/wait/present sequence.
    always_comb begin
        state_next    = state_reg;
        tmo_cnt_next  = tmo_cnt_reg;
        str_cnt_next  = str_cnt_reg;
        miss_cnt_next = miss_cnt_reg;
        data_next     = data_reg;
        fault_next    = fault_reg;
        adc_start     = 1'b0;
        data_ready    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (tick) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                adc_start    = 1'b1;
                tmo_cnt_next = '0;
                state_next   = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the timeout cycle still counts.
                if (adc_done) begin
                    data_next     = fault_reg ? FAULT_DATA : adc_data;
                    miss_cnt_next = '0;
                    str_cnt_next  = '0;
                    state_next    = ST_PRESENT;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    miss_cnt_next = miss_inc;
                    fault_next    = miss_fault;
                    if (miss_fault) begin
                        data_next    = FAULT_DATA;
                        str_cnt_next = '0;
                        state_next   = ST_PRESENT;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            ST_PRESENT: begin
                data_ready = 1'b1;
                if (str_cnt_reg == STR_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    str_cnt_next = str_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tsal_sample_sequencer.sv
// Bench for tsal_sample_sequencer: two instances (16- and 8-cycle sample
// periods) share stimulus, each with its own ADC responder. A timeline model
// predicts every output each cycle; directed scenarios add literal checks.
module tb_tsal_sample_sequencer;
    import tsal_pkg::*;

    localparam int NI  = 2;
    localparam int TMO = 8;
    localparam int STB = 2;
    localparam int LIM = 3;
    localparam int BIG = 32'h3fff_ffff;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [1:0]       adc_start_v;
    logic [1:0]       adc_done_v;
    logic [1:0][7:0]  adc_data_v;
    logic [1:0][7:0]  data_v;
    logic [1:0]       data_ready_v;
    logic [1:0]       fault_v;
    logic [1:0]       overrun_v;

    always #5 clk = ~clk;

    tsal_sample_sequencer #(
        .SAMPLE_DIV(16), .TIMEOUT_CYC(TMO), .STROBE_CYC(STB), .FAULT_LIMIT(LIM)
    ) u0 (
        .clk(clk), .rst(rst), .enable(enable),
        .adc_start(adc_start_v[0]), .adc_done(adc_done_v[0]), .adc_data(adc_data_v[0]),
        .data(data_v[0]), .data_ready(data_ready_v[0]), .fault(fault_v[0]), .overrun(overrun_v[0])
    );

    tsal_sample_sequencer #(
        .SAMPLE_DIV(8), .TIMEOUT_CYC(TMO), .STROBE_CYC(STB), .FAULT_LIMIT(LIM)
    ) u1 (
        .clk(clk), .rst(rst), .enable(enable),
        .adc_start(adc_start_v[1]), .adc_done(adc_done_v[1]), .adc_data(adc_data_v[1]),
        .data(data_v[1]), .data_ready(data_ready_v[1]), .fault(fault_v[1]), .overrun(overrun_v[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // ADC responder controls
    int          adc_delay = 3;     // cycles from adc_start to adc_done; 0 = silent
    logic [7:0]  adc_val   = 8'd120;
    bit          rand_mode = 1'b0;
    bit          spur      = 1'b0;  // one-cycle spurious done on u0
    bit          start_seen [NI];
    int          pend [NI] = '{-1, -1};
    logic [7:0]  pval [NI];

    // Timeline model: each instance has at most one sequence in flight,
    // described by its start cycle, last busy cycle and strobe window.
    int          m_cyc = 0;
    int          m_cnt   [NI] = '{0, 0};
    int          m_start [NI] = '{-1, -1};
    int          m_end   [NI] = '{-1, -1};
    int          m_plo   [NI] = '{0, 0};
    int          m_miss  [NI] = '{0, 0};
    bit          m_res   [NI];
    bit          m_pres  [NI];
    bit          m_fault [NI];
    logic [7:0]  m_data  [NI];
    bit          m_tick, m_b;

    // Monitors
    bit          e_busy, e_start, e_ready, e_over;
    bit          prev_ready [NI];
    int          n_rise [NI] = '{0, 0};
    int          n_start [NI] = '{0, 0};
    int          n_over [NI] = '{0, 0};
    int          mon_done_last = 0;
    int          mon_rise = 0;
    int          mon_len = 0;
    int          mon_len_last = 0;

    function automatic int div_of(input int i);
        return (i == 0) ? 16 : 8;
    endfunction

    function automatic bit m_busy(input int i, input int c);
        return (m_start[i] >= 0) && (c >= m_start[i]) && (c <= m_end[i]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model update at each active edge, using the inputs of the ending cycle.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst) begin
                m_cnt[i] = 0; m_start[i] = -1; m_end[i] = -1; m_plo[i] = 0; m_miss[i] = 0;
                m_res[i] = 1'b0; m_pres[i] = 1'b0; m_fault[i] = 1'b0; m_data[i] = 8'd0;
            end else begin
                m_tick = enable && (m_cnt[i] == div_of(i) - 1);
                m_b    = m_busy(i, m_cyc);
                if (!m_b && m_tick) begin
                    m_start[i] = m_cyc + 1;
                    m_end[i]   = BIG;
                    m_res[i]   = 1'b0;
                    m_pres[i]  = 1'b0;
                end else if (m_b && !m_res[i] && (m_cyc > m_start[i])) begin
                    if (adc_done_v[i]) begin
                        m_res[i]  = 1'b1;
                        m_pres[i] = 1'b1;
                        m_plo[i]  = m_cyc + 1;
                        m_end[i]  = m_cyc + STB;
                        m_miss[i] = 0;
                        m_data[i] = m_fault[i] ? 8'hFF : adc_data_v[i];
                    end else if (m_cyc == m_start[i] + TMO) begin
                        m_res[i]  = 1'b1;
                        m_miss[i] = (m_miss[i] + 1 > LIM) ? LIM : m_miss[i] + 1;
                        if (m_miss[i] == LIM) m_fault[i] = 1'b1;
                        if (m_fault[i]) begin
                            m_pres[i] = 1'b1;
                            m_plo[i]  = m_cyc + 1;
                            m_end[i]  = m_cyc + STB;
                            m_data[i] = 8'hFF;
                        end else begin
                            m_end[i] = m_cyc;
                        end
                    end
                end
                m_cnt[i] = !enable ? 0 : ((m_cnt[i] == div_of(i) - 1) ? 0 : m_cnt[i] + 1);
            end
        end
        m_cyc++;
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) start_seen[i] = adc_start_v[i];
        if (rst === 1'b1) begin
            for (int i = 0; i < NI; i++) begin
                e_busy  = m_busy(i, m_cyc);
                e_start = (m_start[i] >= 0) && (m_cyc == m_start[i]);
                e_ready = e_busy && m_pres[i] && (m_cyc >= m_plo[i]);
                e_over  = enable && (m_cnt[i] == div_of(i) - 1) && e_busy;
                chk($sformatf("u%0d.adc_start", i),  {31'd0, adc_start_v[i]},  {31'd0, e_start});
                chk($sformatf("u%0d.data_ready", i), {31'd0, data_ready_v[i]}, {31'd0, e_ready});
                chk($sformatf("u%0d.overrun", i),    {31'd0, overrun_v[i]},    {31'd0, e_over});
                chk($sformatf("u%0d.fault", i),      {31'd0, fault_v[i]},      {31'd0, m_fault[i]});
                chk($sformatf("u%0d.data", i),       {24'd0, data_v[i]},       {24'd0, m_data[i]});

                if (adc_start_v[i]) n_start[i]++;
                if (overrun_v[i]) n_over[i]++;
                if (data_ready_v[i] && !prev_ready[i]) begin
                    n_rise[i]++;
                    if (i == 0) begin
                        mon_rise = cyc;
                        mon_len  = 1;
                        $display("[cyc %0d] u0 sample data=0x%02h fault=%0b", cyc, data_v[0], fault_v[0]);
                    end
                end else if (data_ready_v[i] && i == 0) begin
                    mon_len++;
                end else if (!data_ready_v[i] && prev_ready[i] && i == 0) begin
                    mon_len_last = mon_len;
                end
                prev_ready[i] = data_ready_v[i];
            end
            if (adc_done_v[0]) mon_done_last = cyc;
        end else begin
            for (int i = 0; i < NI; i++) prev_ready[i] = 1'b0;
        end
    end

    // Advance n cycles; inputs change 1 time unit after each active edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
            #1;
            for (int i = 0; i < NI; i++) begin
                if (start_seen[i]) begin
                    int d;
                    d       = rand_mode ? $urandom_range(0, 11) : adc_delay;
                    pend[i] = (d > 0) ? (cyc - 1 + d) : -1;
                    pval[i] = rand_mode ? 8'($urandom) : adc_val;
                end
                adc_done_v[i] = (pend[i] == cyc) || ((i == 0) && spur);
                adc_data_v[i] = (pend[i] == cyc) ? pval[i] : (spur ? 8'd99 : 8'($urandom));
            end
            spur = 1'b0;
            if (rand_mode) begin
                spur = ($urandom_range(0, 49) == 0);
                if ($urandom_range(0, 199) == 0) enable = ~enable;
            end
        end
    endtask

    task automatic wait_start(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            step(1);
            if (adc_start_v[0]) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_start(%s): got no adc_start in 64 cycles, expected one", tag);
        end
    endtask

    task automatic run_seq(input int delay, input logic [7:0] val);
        adc_delay = delay;
        adc_val   = val;
        wait_start($sformatf("delay %0d", delay));
        step(TMO + STB + 3);
    endtask

    int rel, s1, s2, r0, ov0, ov1, st0;
    bit seen;

    initial begin
        rst        = 1'b0;
        enable     = 1'b1;
        adc_done_v = '0;
        adc_data_v = '0;
        step(3);

        // Reset holds every output low even with enable high
        chk("reset.adc_start",  {30'd0, adc_start_v},  32'd0);
        chk("reset.data_ready", {30'd0, data_ready_v}, 32'd0);
        chk("reset.fault",      {30'd0, fault_v},      32'd0);
        chk("reset.overrun",    {30'd0, overrun_v},    32'd0);
        chk("reset.data",       {16'd0, data_v},       32'd0);

        // First conversion request: 16-cycle period plus START latency
        rst = 1'b1;
        rel = cyc;
        wait_start("first");
        chk("first_start_edges", cyc - rel + 1, 17);
        s1 = cyc;

        // Normal sampling: done 3 cycles after start with 120
        step(TMO + STB + 3);
        chk("normal.data", {24'd0, data_v[0]}, 32'd120);
        chk("normal.strobe_len", mon_len_last, STB);
        chk("normal.ready_latency", mon_rise - mon_done_last, 1);
        chk("normal.fault", {31'd0, fault_v[0]}, 32'd0);
        ov0 = n_over[0];
        wait_start("period");
        s2 = cyc;
        chk("normal.period", s2 - s1, 16);
        step(TMO + STB + 3);
        r0 = n_rise[0];
        run_seq(3, 8'd120);
        run_seq(3, 8'd120);
        chk("normal.strobes", n_rise[0] - r0, 2);
        chk("normal.no_overrun", n_over[0] - ov0, 0);

        // Silent ADC: two quiet misses, third latches fault and presents 0xFF
        r0 = n_rise[0];
        run_seq(0, 8'd0);
        run_seq(0, 8'd0);
        chk("fault.no_strobe_on_miss", n_rise[0] - r0, 0);
        chk("fault.not_yet", {31'd0, fault_v[0]}, 32'd0);
        run_seq(0, 8'd0);
        chk("fault.set", {31'd0, fault_v[0]}, 32'd1);
        chk("fault.data", {24'd0, data_v[0]}, 32'd255);
        chk("fault.strobe", n_rise[0] - r0, 1);
        chk("fault.strobe_len", mon_len_last, STB);
        run_seq(3, 8'd10);
        chk("fault.forced_data", {24'd0, data_v[0]}, 32'd255);
        chk("fault.sticky", {31'd0, fault_v[0]}, 32'd1);

        // Reset during PRESENT drops the strobe and clears state at once
        adc_delay = 3;
        seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            step(1);
            seen = data_ready_v[0];
        end
        chk("rst_mid.reached_present", {31'd0, seen}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_mid.data_ready", {31'd0, data_ready_v[0]}, 32'd0);
        chk("rst_mid.data", {24'd0, data_v[0]}, 32'd0);
        chk("rst_mid.fault", {31'd0, fault_v[0]}, 32'd0);
        step(2);
        rst = 1'b1;

        // Recovery: a good sample clears the miss run
        run_seq(0, 8'd0);
        run_seq(0, 8'd0);
        run_seq(3, 8'd50);
        chk("recover.data", {24'd0, data_v[0]}, 32'd50);
        chk("recover.fault", {31'd0, fault_v[0]}, 32'd0);
        run_seq(0, 8'd0);
        chk("recover.single_miss", {31'd0, fault_v[0]}, 32'd0);

        // Done on exactly the timeout cycle is still a valid sample
        r0 = n_rise[0];
        run_seq(TMO, 8'd77);
        chk("edge.done_at_timeout", {24'd0, data_v[0]}, 32'd77);
        chk("edge.done_at_timeout_strobe", n_rise[0] - r0, 1);

        // Spurious done while idle is ignored
        r0   = n_rise[0];
        spur = 1'b1;
        step(2);
        chk("edge.spurious_data", {24'd0, data_v[0]}, 32'd77);
        chk("edge.spurious_strobe", n_rise[0] - r0, 0);

        // Slow ADC against the 8-cycle instance causes overruns
        ov0 = n_over[0];
        ov1 = n_over[1];
        run_seq(7, 8'd5);
        run_seq(7, 8'd6);
        chk("edge.u1_overrun", {31'd0, n_over[1] > ov1}, 32'd1);
        chk("edge.u0_no_overrun", n_over[0] - ov0, 0);

        // Enable dropped mid-WAIT: sequence completes, nothing new starts
        adc_delay = 3;
        adc_val   = 8'd33;
        wait_start("enable_drop");
        step(2);
        enable = 1'b0;
        st0 = n_start[0];
        r0  = n_rise[0];
        step(40);
        chk("enable.completed", n_rise[0] - r0, 1);
        chk("enable.data", {24'd0, data_v[0]}, 32'd33);
        chk("enable.no_new_start", n_start[0] - st0, 0);
        enable = 1'b1;

        // Randomised ADC latency/data, spurious dones, enable toggles, resets
        rand_mode = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            step(1);
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b0;
                step(1);
                rst = 1'b1;
            end
        end
        rand_mode = 1'b0;
        spur      = 1'b0;
        step(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
